// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: fetch/decode/execute sequencing with a memory-wait watchdog.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       fault,
    output logic [3:0]       state_dbg
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        fault_q, fault_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout;

    logic       req_c, we_c, irwe_c, pcwe_c, regwe_c, alub_c;
    logic [1:0] pcsrc_c, regdst_c, wbsrc_c;
    logic [2:0] aluop_c;

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        nxt = HALT;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) nxt = EXEC_R;
                else if (fn == FN_JR)                             nxt = JUMP;
            end
            OP_XORI:        nxt = EXEC_I;
            OP_LW, OP_SW:   nxt = MEM_ADDR;
            OP_BNE:         nxt = BRANCH;
            OP_J, OP_JAL:   nxt = JUMP;
            default:        nxt = HALT;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_SUB:  op = 3'b001;
            FN_SLT:  op = 3'b011;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    // A pending request times out on the cycle its wait count would reach MAX_WAIT; an ack that cycle still wins.
    assign timeout = !mem_ack && (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        irwe_c   = 1'b0;
        pcwe_c   = 1'b0;
        pcsrc_c  = 2'b00;
        regwe_c  = 1'b0;
        regdst_c = 2'b00;
        wbsrc_c  = 2'b00;
        alub_c   = 1'b0;
        aluop_c  = 3'b000;
        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    irwe_c  = 1'b1;
                    pcwe_c  = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = HALT;
                    fault_d = 2'b10;
                end
            end
            DECODE: begin
                state_d = decode_next(opcode, funct);
                if (state_d == HALT) fault_d = 2'b01;
            end
            EXEC_R: begin
                aluop_c = r_alu_op(funct);
                state_d = WB_R;
            end
            WB_R: begin
                regwe_c  = 1'b1;
                regdst_c = 2'b01;
                aluop_c  = r_alu_op(funct);
                state_d  = FETCH;
            end
            EXEC_I: begin
                alub_c  = 1'b1;
                aluop_c = 3'b010;
                state_d = WB_I;
            end
            WB_I: begin
                regwe_c = 1'b1;
                alub_c  = 1'b1;
                aluop_c = 3'b010;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                alub_c  = 1'b1;
                state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    state_d = WB_MEM;
                end else if (timeout) begin
                    state_d = HALT;
                    fault_d = 2'b10;
                end
            end
            WB_MEM: begin
                regwe_c = 1'b1;
                wbsrc_c = 2'b01;
                state_d = FETCH;
            end
            MEM_WR: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                if (mem_ack) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = HALT;
                    fault_d = 2'b10;
                end
            end
            BRANCH: begin
                aluop_c = 3'b001;
                if (!zero) begin
                    pcwe_c  = 1'b1;
                    pcsrc_c = 2'b01;
                end
                state_d = FETCH;
            end
            JUMP: begin
                pcwe_c  = 1'b1;
                pcsrc_c = (opcode == OP_RTYPE) ? 2'b11 : 2'b10;
                if (opcode == OP_JAL) begin
                    regwe_c  = 1'b1;
                    regdst_c = 2'b10;
                    wbsrc_c  = 2'b10;
                end
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        if (state_d != state_q || mem_ack) wait_d = '0;
        else if (req_c)                    wait_d = wait_q + WAIT_W'(1);
        else                               wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            fault_q <= 2'b00;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // Everything is held at zero while reset is asserted, so an abandoned instruction writes nothing.
    assign mem_req   = rst_n & req_c;
    assign mem_we    = rst_n & we_c;
    assign ir_we     = rst_n & irwe_c;
    assign pc_we     = rst_n & pcwe_c;
    assign reg_we    = rst_n & regwe_c;
    assign alu_src_b = rst_n & alub_c;
    assign pc_src    = rst_n ? pcsrc_c  : 2'b00;
    assign reg_dst   = rst_n ? regdst_c : 2'b00;
    assign wb_src    = rst_n ? wbsrc_c  : 2'b00;
    assign alu_op    = rst_n ? aluop_c  : 3'b000;
    assign fault     = rst_n ? fault_q  : 2'b00;
    assign state_dbg = rst_n ? state_q  : 4'd0;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (state_q != FETCH && state_d == FETCH) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = rst_n ? retired_q : '0;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench: each instruction is expanded from its class into an expected per-cycle trace.
module tb_multicycle_ctrl;
    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 32;

    logic clk, rst_n, zero, mem_ack;
    logic [5:0] opcode, funct;
    logic mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b;
    logic [1:0] pc_src, reg_dst, wb_src, fault;
    logic [2:0] alu_op;
    logic [3:0] state_dbg;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired;
`endif

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
        .wb_src(wb_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .fault(fault),
        .state_dbg(state_dbg)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       regwe;
        logic [1:0] regdst, wbsrc;
        logic       alub;
        logic [2:0] aluop;
        logic [1:0] flt;
    } rec_t;

    typedef struct packed {
        logic ack;
        logic z;
        logic last;
        rec_t r;
    } step_t;

    step_t q[$];
    rec_t  got;
    int    n_checks = 0;
    int    n_pass   = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    assign got = {state_dbg, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we,
                  reg_dst, wb_src, alu_src_b, alu_op, fault};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic rec_t blank(input logic [3:0] st);
        rec_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input rec_t r, input logic ack, input logic z, input logic last);
        step_t s;
        s.r = r; s.ack = ack; s.z = z; s.last = last;
        q.push_back(s);
    endtask

    task automatic push_halt(input logic [1:0] f, input int n);
        rec_t r;
        r = blank(4'd12);
        r.flt = f;
        for (int i = 0; i < n; i++) push(r, rbit(), rbit(), 1'b0);
    endtask

    // Unacknowledged request cycles; a wait of MAX_WAIT or more ends in a timeout halt.
    task automatic push_waits(input rec_t r, input int waits, output bit halted);
        halted = (waits >= MAX_WAIT);
        for (int i = 0; i < (halted ? MAX_WAIT : waits); i++) push(r, 1'b0, rbit(), 1'b0);
        if (halted) push_halt(2'b10, 4);
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input logic z, output bit halted);
        rec_t r;
        opcode = op;
        funct  = fn;
        r = blank(4'd0); r.req = 1'b1;
        push_waits(r, wf, halted);
        if (halted) return;
        r.irwe = 1'b1; r.pcwe = 1'b1;
        push(r, 1'b1, rbit(), 1'b0);
        push(blank(4'd1), rbit(), rbit(), 1'b0);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a)) begin
            r = blank(4'd2);
            r.aluop = (fn == 6'h20) ? 3'b000 : (fn == 6'h22) ? 3'b001 : 3'b011;
            push(r, rbit(), rbit(), 1'b0);
            r.st = 4'd7; r.regwe = 1'b1; r.regdst = 2'b01;
            push(r, rbit(), rbit(), 1'b1);
        end else if (op == 6'h0e) begin
            r = blank(4'd3); r.alub = 1'b1; r.aluop = 3'b010;
            push(r, rbit(), rbit(), 1'b0);
            r.st = 4'd8; r.regwe = 1'b1;
            push(r, rbit(), rbit(), 1'b1);
        end else if (op == 6'h23 || op == 6'h2b) begin
            r = blank(4'd4); r.alub = 1'b1;
            push(r, rbit(), rbit(), 1'b0);
            r = blank((op == 6'h23) ? 4'd5 : 4'd6);
            r.req = 1'b1; r.we = (op == 6'h2b);
            push_waits(r, wm, halted);
            if (halted) return;
            push(r, 1'b1, rbit(), op == 6'h2b);
            if (op == 6'h23) begin
                r = blank(4'd9); r.regwe = 1'b1; r.wbsrc = 2'b01;
                push(r, rbit(), rbit(), 1'b1);
            end
        end else if (op == 6'h05) begin
            r = blank(4'd10); r.aluop = 3'b001;
            if (!z) begin r.pcwe = 1'b1; r.pcsrc = 2'b01; end
            push(r, rbit(), z, 1'b1);
        end else if ((op == 6'h00 && fn == 6'h08) || op == 6'h02 || op == 6'h03) begin
            r = blank(4'd11); r.pcwe = 1'b1;
            r.pcsrc = (op == 6'h00) ? 2'b11 : 2'b10;
            if (op == 6'h03) begin r.regwe = 1'b1; r.regdst = 2'b10; r.wbsrc = 2'b10; end
            push(r, rbit(), rbit(), 1'b1);
        end else begin
            push_halt(2'b01, 20);
            halted = 1'b1;
        end
    endtask

    // Entered and left at a falling edge: drive, settle, compare, then advance one cycle.
    task automatic run_queue(input string tag, input int limit);
        int n;
        step_t s;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            s = q.pop_front();
            mem_ack = s.ack;
            zero    = s.z;
            #1;
            check(tag, got, s.r);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
            check({tag, "_retired"}, retired, exp_ret);
`endif
            if (s.last) exp_ret = exp_ret + 1'b1;
            n++;
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ack = rbit();
            zero    = rbit();
            #1;
            check("reset_outs", got, 64'd0);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
            check("reset_retired", retired, 64'd0);
`endif
            @(negedge clk);
        end
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        exp_ret = '0;
    endtask

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a || fn == 6'h08);
        return (op == 6'h0e || op == 6'h23 || op == 6'h2b || op == 6'h05 || op == 6'h02 || op == 6'h03);
    endfunction

    logic [5:0] lop [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0e, 6'h23, 6'h2b, 6'h05, 6'h02, 6'h03};
    logic [5:0] lfn [10] = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        bit h;
        logic [5:0] op, fn;
        int wf, wm;
        rst_n = 1'b0; mem_ack = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        @(negedge clk);
        do_reset(2);

        gen_instr(6'h00, 6'h20, 0, 0, 1'b0, h); run_queue("add", 1000);
        gen_instr(6'h23, 6'h11, 0, 3, 1'b0, h); run_queue("lw_wait3", 1000);
        gen_instr(6'h05, 6'h00, 1, 0, 1'b1, h); run_queue("bne_z1", 1000);
        gen_instr(6'h05, 6'h00, 0, 0, 1'b0, h); run_queue("bne_z0", 1000);
        gen_instr(6'h03, 6'h00, 0, 0, 1'b0, h); run_queue("jal", 1000);
        gen_instr(6'h00, 6'h08, 2, 0, 1'b0, h); run_queue("jr", 1000);
        gen_instr(6'h2b, 6'h00, 0, 2, 1'b0, h); run_queue("sw", 1000);
        gen_instr(6'h0e, 6'h00, 0, 0, 1'b0, h); run_queue("xori", 1000);

        gen_instr(6'h3f, 6'h00, 0, 0, 1'b0, h); run_queue("illegal", 1000);
        do_reset(1);
        gen_instr(6'h00, 6'h22, 0, 0, 1'b0, h); run_queue("sub_after_rst", 1000);

        gen_instr(6'h00, 6'h20, MAX_WAIT, 0, 1'b0, h); run_queue("fetch_timeout", 1000);
        do_reset(1);
        gen_instr(6'h00, 6'h2a, MAX_WAIT - 1, 0, 1'b0, h); run_queue("fetch_ack_last", 1000);
        gen_instr(6'h23, 6'h00, 12, MAX_WAIT, 1'b0, h); run_queue("lw_timeout", 1000);
        do_reset(1);
        gen_instr(6'h2b, 6'h00, 12, MAX_WAIT - 1, 1'b0, h); run_queue("sw_long", 1000);

        gen_instr(6'h2b, 6'h00, 0, 6, 1'b0, h); run_queue("sw_abandon", 5);
        do_reset(1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) != 0) begin
                int k;
                k  = $urandom_range(0, 9);
                op = lop[k];
                fn = (op == 6'h00) ? lfn[k] : 6'($urandom_range(0, 63));
            end else begin
                do begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                end while (is_legal(op, fn));
            end
            wf = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 2);
            wm = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 3);
            gen_instr(op, fn, wf, wm, rbit(), h);
            run_queue("random", 1000);
            if (h) do_reset(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
